// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver. It is the receive-side partner of the 8N1 transmitter and uses the same baud parameters.
//   The serial input passes through a 2-flop synchroniser.
//   A start bit counts only if the line is still low at half a bit.
//   It then samples 8 data bits, LSB first, at mid-bit.
//   Finally it checks the stop bit.
//   A good byte gives a one-cycle axiov pulse. A bad stop bit gives a one-cycle frame_err pulse.
// Ports:
//   clk       system clock
//   rst       asynchronous reset, active low
//   rxd       serial line, idle high, asynchronous to clk
//   axiod     last good byte; LSB is the first data bit received
//   axiov     one-cycle pulse; axiod is valid in that cycle
//   frame_err one-cycle pulse; the stop bit was sampled as 0
//   busy      high whenever the FSM is not in IDLE
// Optional feature: define UART_RX_MAJORITY_EN to use 3-sample majority voting.
//   Each bit becomes the majority of the samples at the nominal point -1, 0 and +1.
//   Decisions move one cycle later, so axiov arrives one cycle later.
//   This mode needs CYCLES_PER_BIT >= 4.
module uart_rx #(
  parameter int BAUD    = 9600,
  parameter int CLK_FRQ = 100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] axiod,
  output logic       axiov,
  output logic       frame_err,
  output logic       busy
);

  localparam int CYCLES_PER_BIT = CLK_FRQ / BAUD;
  localparam int HALF_BIT       = CYCLES_PER_BIT / 2;
  localparam int CW             = $clog2(CYCLES_PER_BIT + 1);
  localparam logic [CW-1:0] FULL_C = CW'(CYCLES_PER_BIT);
  localparam logic [CW-1:0] HALF_C = CW'(HALF_BIT);
  localparam logic [CW-1:0] ONE_C  = CW'(1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] count, count_nxt;
  logic [2:0]    idx, idx_nxt;
  logic [7:0]    shift, shift_nxt, axiod_nxt;
  logic          axiov_nxt, frame_err_nxt;
  logic          sync0, rxd_s;
  logic          hit, decide, bit_val;

  // Two-flop synchroniser. It resets to the idle (high) level, so reset never fakes a start bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync0 <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      sync0 <= rxd;
      rxd_s <= sync0;
    end
  end

  // hit marks the nominal sample point of the current bit.
  always_comb begin
    hit = 1'b0;
    case (state)
      START:      hit = (count == HALF_C);
      DATA, STOP: hit = (count == FULL_C);
      default:    hit = 1'b0;
    endcase
  end

`ifdef UART_RX_MAJORITY_EN
  // The bit decision waits one cycle after the nominal point, so the +1 sample exists.
  // The counter keeps running from the nominal point, so bit timing does not drift.
  logic rxd_p, rxd_pp, hit_d;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rxd_p  <= 1'b1;
      rxd_pp <= 1'b1;
      hit_d  <= 1'b0;
    end else begin
      rxd_p  <= rxd_s;
      rxd_pp <= rxd_p;
      hit_d  <= hit;
    end
  end
  assign decide  = hit_d;
  assign bit_val = (rxd_s & rxd_p) | (rxd_s & rxd_pp) | (rxd_p & rxd_pp);
`else
  assign decide  = hit;
  assign bit_val = rxd_s;
`endif

  always_comb begin
    state_nxt     = state;
    count_nxt     = count;
    idx_nxt       = idx;
    shift_nxt     = shift;
    axiod_nxt     = axiod;
    axiov_nxt     = 1'b0;
    frame_err_nxt = 1'b0;
    // The bit counter restarts at each sample point, so later samples stay at mid-bit.
    if (state == START || state == DATA || state == STOP)
      count_nxt = hit ? ONE_C : count + ONE_C;
    case (state)
      IDLE: if (!rxd_s) begin
        state_nxt = START;
        count_nxt = ONE_C;
      end
      START: if (decide) begin
        if (!bit_val) begin
          state_nxt = DATA;
          idx_nxt   = 3'd0;
        end else begin
          // The line went high again before half a bit: treat it as a glitch.
          state_nxt = IDLE;
          count_nxt = '0;
        end
      end
      DATA: if (decide) begin
        shift_nxt[idx] = bit_val;
        if (idx == 3'd7) state_nxt = STOP;
        else             idx_nxt   = idx + 3'd1;
      end
      STOP: if (decide) begin
        count_nxt = '0;
        if (bit_val) begin
          axiod_nxt = shift;
          axiov_nxt = 1'b1;
          state_nxt = IDLE;
        end else begin
          frame_err_nxt = 1'b1;
          state_nxt     = WAIT_IDLE;
        end
      end
      // A break (line held low) must go high before the receiver re-arms.
      WAIT_IDLE: if (rxd_s) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      count     <= '0;
      idx       <= '0;
      shift     <= '0;
      axiod     <= '0;
      axiov     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      count     <= count_nxt;
      idx       <= idx_nxt;
      shift     <= shift_nxt;
      axiod     <= axiod_nxt;
      axiov     <= axiov_nxt;
      frame_err <= frame_err_nxt;
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed testbench for uart_rx at 16 clocks per bit.
//   A table of frames is applied in a loop.
//   Hand-written sequences cover back-to-back frames, a start glitch, and reset in mid-frame.
module tb_uart_rx;
  localparam int CLK_FRQ = 100_000_000;
  localparam int BAUD    = 6_250_000;
  localparam int CPB     = 16;
  localparam int HALF    = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxd;
  logic [7:0] axiod;
  logic       axiov, frame_err, busy;

  uart_rx #(.BAUD(BAUD), .CLK_FRQ(CLK_FRQ)) dut (
    .clk(clk), .rst(rst), .rxd(rxd),
    .axiod(axiod), .axiov(axiov), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int nv = 0, nfe = 0, both = 0;
  logic [7:0] vq[$];
  int         cq[$];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (axiov) begin
      nv++;
      vq.push_back(axiod);
      cq.push_back(cyc);
    end
    if (frame_err) nfe++;
    if (axiov && frame_err) both++;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic drive_cycles(input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rxd = v;
    end
  endtask

  // One 8N1 frame. With glitch set, each data bit is inverted for one cycle at its mid-bit sample point.
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic glitch);
    drive_cycles(1'b0, CPB);
    for (int b = 0; b < 8; b++)
      for (int c = 0; c < CPB; c++) begin
        @(negedge clk);
        rxd = d[b] ^ (glitch && c == HALF);
      end
    drive_cycles(stop, CPB);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    logic       glitch;
    int         hold_low;
    int         exp_nv;
    logic [7:0] exp_d;
    int         exp_fe;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int nv0, fe0, q0, bc;
    logic [7:0] glitch_exp;
`ifdef UART_RX_MAJORITY_EN
    glitch_exp = 8'hC3;
`else
    glitch_exp = 8'h3C;
`endif
    vecs[0] = '{8'hA5, 1'b1, 1'b0, 0,  1, 8'hA5, 0};
    vecs[1] = '{8'h3C, 1'b0, 1'b0, 50, 0, 8'hA5, 1};
    vecs[2] = '{8'h81, 1'b1, 1'b0, 0,  1, 8'h81, 0};
    vecs[3] = '{8'hC3, 1'b1, 1'b1, 0,  1, glitch_exp, 0};
    vecs[4] = '{8'h00, 1'b1, 1'b0, 0,  1, 8'h00, 0};
    vecs[5] = '{8'hFF, 1'b1, 1'b0, 0,  1, 8'hFF, 0};
    vecs[6] = '{8'h7E, 1'b1, 1'b0, 0,  1, 8'h7E, 0};

    rxd = 1'b1;
    rst = 1'b1;
    #2 rst = 1'b0;
    #20;
    chk("reset_axiod", axiod, 0);
    chk("reset_axiov", axiov, 0);
    chk("reset_frame_err", frame_err, 0);
    chk("reset_busy", busy, 0);
    @(negedge clk) rst = 1'b1;
    drive_cycles(1'b1, 10);

    for (int i = 0; i < 7; i++) begin
      nv0 = nv;
      fe0 = nfe;
      send_frame(vecs[i].data, vecs[i].stop, vecs[i].glitch);
      if (vecs[i].hold_low > 0) drive_cycles(1'b0, vecs[i].hold_low);
      drive_cycles(1'b1, 20);
      chk($sformatf("vec%0d_axiov_count", i), nv - nv0, vecs[i].exp_nv);
      chk($sformatf("vec%0d_axiod", i), axiod, vecs[i].exp_d);
      chk($sformatf("vec%0d_frame_err_count", i), nfe - fe0, vecs[i].exp_fe);
      chk($sformatf("vec%0d_busy_after", i), busy, 0);
    end

    // Back-to-back frames with no idle gap.
    q0 = vq.size();
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    drive_cycles(1'b1, 20);
    chk("b2b_pulse_count", vq.size() - q0, 2);
    if (vq.size() >= q0 + 2) begin
      chk("b2b_first_byte", vq[q0], 8'h00);
      chk("b2b_second_byte", vq[q0+1], 8'hFF);
      chk_range("b2b_gap_cycles", cq[q0+1] - cq[q0], CPB*10 - 1, CPB*10 + 1);
    end

    // A 4-cycle low glitch from idle must be dropped.
    nv0 = nv;
    fe0 = nfe;
    bc = 0;
    for (int i = 0; i < 34; i++) begin
      @(negedge clk);
      rxd = (i < 4) ? 1'b0 : 1'b1;
      if (busy) bc++;
    end
    chk_range("glitch_busy_cycles", bc, 1, HALF + 3);
    chk("glitch_axiov_count", nv - nv0, 0);
    chk("glitch_frame_err_count", nfe - fe0, 0);
    chk("glitch_busy_after", busy, 0);

    // Reset in mid-DATA: outputs clear at once and there is no stale pulse afterwards.
    nv0 = nv;
    fe0 = nfe;
    drive_cycles(1'b0, CPB);
    drive_cycles(1'b0, CPB);
    drive_cycles(1'b1, CPB);
    drive_cycles(1'b0, 10);
    chk("middata_busy", busy, 1);
    #2 rst = 1'b0;
    #1;
    chk("rst_async_axiod", axiod, 0);
    chk("rst_async_axiov", axiov, 0);
    chk("rst_async_frame_err", frame_err, 0);
    chk("rst_async_busy", busy, 0);
    rxd = 1'b1;
    drive_cycles(1'b1, 3);
    rst = 1'b1;
    drive_cycles(1'b1, 200);
    chk("rst_no_stale_axiov", nv - nv0, 0);
    chk("rst_no_stale_frame_err", nfe - fe0, 0);
    send_frame(8'h5A, 1'b1, 1'b0);
    drive_cycles(1'b1, 20);
    chk("post_rst_axiov_count", nv - nv0, 1);
    chk("post_rst_axiod", axiod, 8'h5A);

    chk("axiov_and_frame_err_together", both, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
